// File: rtl/load_store_unit.sv
// Load/store unit: one memory access per request with timeout and a one-cycle response pulse.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word requests.
module load_store_unit #(
    parameter int WORD_SIZE = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_store,
    input  logic [1:0]           req_size,
    input  logic                 req_sign,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 read_one,
    output logic                 read_sign_one,
    output logic [WORD_SIZE-1:0] read_addr_one,
    output logic [1:0]           read_size_one,
    input  logic [WORD_SIZE-1:0] read_data_one,
    input  logic                 read_valid_one,
    output logic                 wren,
    output logic [1:0]           write_size,
    output logic [WORD_SIZE-1:0] write_addr,
    output logic [WORD_SIZE-1:0] write_data,
    input  logic                 write_valid
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WORD_SIZE-1:0]   addr_q;
    logic [WORD_SIZE-1:0]   wdata_q;
    logic [1:0]             size_q;
    logic                   sign_q;
    logic                   bad_req;
    logic                   cnt_last;

    always_comb begin
        bad_req = (req_size == 2'd3);
`ifdef LSU_MISALIGN_CHECK_EN
        if (req_size == 2'd1 && req_addr[0])
            bad_req = 1'b1;
        if (req_size == 2'd2 && req_addr[1:0] != 2'b00)
            bad_req = 1'b1;
`endif
    end

    assign cnt_last  = (cnt == CW'(TIMEOUT - 1));
    assign req_ready = (state == IDLE) && !reset;

    assign read_addr_one = addr_q;
    assign read_size_one = size_q;
    assign read_sign_one = sign_q;
    assign write_addr    = addr_q;
    assign write_size    = size_q;
    assign write_data    = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            read_one   <= 1'b0;
            wren       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        sign_q     <= req_sign;
                        cnt        <= '0;
                        resp_rdata <= '0;
                        if (bad_req) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_is_store) begin
                            state <= WRITE;
                            wren  <= 1'b1;
                        end else begin
                            state    <= READ;
                            read_one <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // A valid on the timeout edge still counts as success.
                    if (read_valid_one) begin
                        state      <= RESP;
                        read_one   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= read_data_one;
                    end else if (cnt_last) begin
                        state      <= RESP;
                        read_one   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WRITE: begin
                    if (write_valid || cnt_last) begin
                        state      <= RESP;
                        wren       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= !write_valid;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset/back-to-back
// sequences, and randomized transactions against a transaction-level model.
module tb_load_store_unit;

    localparam int W  = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_store;
    logic [1:0]    req_size;
    logic          req_sign;
    logic [W-1:0]  req_addr;
    logic [W-1:0]  req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [W-1:0]  resp_rdata;
    logic          read_one;
    logic          read_sign_one;
    logic [W-1:0]  read_addr_one;
    logic [1:0]    read_size_one;
    logic [W-1:0]  read_data_one;
    logic          read_valid_one;
    logic          wren;
    logic [1:0]    write_size;
    logic [W-1:0]  write_addr;
    logic [W-1:0]  write_data;
    logic          write_valid;

    load_store_unit #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .read_one(read_one), .read_sign_one(read_sign_one), .read_addr_one(read_addr_one),
        .read_size_one(read_size_one), .read_data_one(read_data_one), .read_valid_one(read_valid_one),
        .wren(wren), .write_size(write_size), .write_addr(write_addr), .write_data(write_data),
        .write_valid(write_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_store;
        logic [1:0]   size;
        logic         sign;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
        int           delay;       // strobe cycle on which memory answers
        logic         exp_err;
        logic [W-1:0] exp_rdata;
        int           exp_strobes;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic sg,
                                input logic [W-1:0] a, input logic [W-1:0] wd,
                                input logic [W-1:0] rd, input int d, input logic e,
                                input logic [W-1:0] er, input int es);
        vec_t v;
        v.is_store = st; v.size = sz; v.sign = sg; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.delay = d; v.exp_err = e; v.exp_rdata = er; v.exp_strobes = es;
        return v;
    endfunction

    // Transaction-level reference: outcome depends only on legality and memory delay.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic bad = (v.size == 2'd3);
`ifdef LSU_MISALIGN_CHECK_EN
        if (v.size == 2'd1 && v.addr[0]) bad = 1'b1;
        if (v.size == 2'd2 && v.addr[1:0] != 2'b00) bad = 1'b1;
`endif
        if (bad) begin
            r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_strobes = 0;
        end else begin
            r.exp_strobes = (v.delay <= TO) ? v.delay : TO;
            r.exp_err     = (v.delay > TO);
            r.exp_rdata   = (!v.is_store && !r.exp_err) ? v.rdata : '0;
        end
        return r;
    endfunction

    // Starts at a negedge with req_ready high; returns at a negedge one cycle after resp_valid.
    task automatic run_txn(input vec_t t, output logic err, output logic [W-1:0] rdata,
                           output int strobes, output int lat, output int bad, output logic ready_after);
        bit done = 0;
        err = 1'b0; rdata = '0; strobes = 0; lat = 0; bad = 0; ready_after = 1'b0;
        req_valid = 1'b1; req_is_store = t.is_store; req_size = t.size; req_sign = t.sign;
        req_addr = t.addr; req_wdata = t.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= TO + 8 && !done; c++) begin
            if (resp_valid) begin
                err = resp_err; rdata = resp_rdata; lat = c; done = 1;
            end else begin
                if (read_one) begin
                    strobes++;
                    if (t.is_store) bad++;
                    if (read_addr_one !== t.addr || read_size_one !== t.size || read_sign_one !== t.sign) bad++;
                end
                if (wren) begin
                    strobes++;
                    if (!t.is_store) bad++;
                    if (write_addr !== t.addr || write_size !== t.size || write_data !== t.wdata) bad++;
                end
                // Stray valids outside the access state must be ignored.
                read_valid_one = read_one ? (strobes == t.delay) : 1'($urandom_range(0, 1));
                write_valid    = wren ? (strobes == t.delay) : 1'($urandom_range(0, 1));
                read_data_one  = read_one ? t.rdata : $urandom;
                @(negedge clk);
            end
        end
        if (done) begin
            read_valid_one = 1'($urandom_range(0, 1));
            write_valid    = 1'($urandom_range(0, 1));
            @(negedge clk);
            ready_after = req_ready && !resp_valid && !read_one && !wren;
            read_valid_one = 1'b0;
            write_valid    = 1'b0;
        end else begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic err, ra;
        logic [W-1:0] rd;
        int st, lat, bad;
        run_txn(v, err, rd, st, lat, bad, ra);
        check({tag, " err"}, W'(err), W'(v.exp_err));
        check({tag, " rdata"}, rd, v.exp_rdata);
        check({tag, " strobes"}, W'(st), W'(v.exp_strobes));
        check({tag, " latency"}, W'(lat), W'(v.exp_strobes + 1));
        check({tag, " strobe fields"}, W'(bad), '0);
        check({tag, " ready after"}, W'(ra), W'(1));
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int rv_seen;

        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = '0; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0; read_data_one = '0; read_valid_one = 1'b0; write_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", W'(req_ready), '0);
        check("reset strobes", W'({read_one, wren}), '0);
        check("reset resp", W'({resp_valid, resp_err}), '0);
        check("reset rdata", resp_rdata, '0);
        check("reset addr/data", read_addr_one | write_addr | write_data, '0);
        reset = 1'b0;
        @(negedge clk);
        check("idle req_ready", W'(req_ready), W'(1));

        vecs.push_back(mk(0, 2, 0, 32'h1004, 32'h0, 32'hDEADBEEF, 3, 0, 32'hDEADBEEF, 3));
        vecs.push_back(mk(1, 0, 0, 32'h1001, 32'hA5, 32'h0, 1, 0, 32'h0, 1));
        vecs.push_back(mk(0, 2, 0, 32'h1008, 32'h0, 32'h11111111, 99, 1, 32'h0, TO));
        vecs.push_back(mk(0, 3, 0, 32'h1000, 32'h0, 32'h22222222, 1, 1, 32'h0, 0));
        vecs.push_back(mk(1, 3, 0, 32'h1000, 32'h33, 32'h0, 1, 1, 32'h0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h2000, 32'hCAFEF00D, 32'h0, TO, 0, 32'h0, TO));
        vecs.push_back(mk(0, 0, 1, 32'h2001, 32'h0, 32'h55, TO + 1, 1, 32'h0, TO));
        vecs.push_back(mk(1, 1, 0, 32'h2002, 32'h1234, 32'h0, 2, 0, 32'h0, 2));
`ifdef LSU_MISALIGN_CHECK_EN
        vecs.push_back(mk(0, 2, 0, 32'h1002, 32'h0, 32'h12345678, 2, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h2003, 32'h0, 32'hFFFF8001, 1, 1, 32'h0, 0));
`else
        vecs.push_back(mk(0, 2, 0, 32'h1002, 32'h0, 32'h12345678, 2, 0, 32'h12345678, 2));
        vecs.push_back(mk(0, 1, 1, 32'h2003, 32'h0, 32'hFFFF8001, 1, 0, 32'hFFFF8001, 1));
`endif
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset during the second READ cycle aborts with no response.
        req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_addr = 32'h3000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort in READ", W'(read_one), W'(1));
        reset = 1'b1;
        @(negedge clk);
        check("abort strobe low", W'({read_one, wren}), '0);
        check("abort ready in reset", W'(req_ready), '0);
        reset = 1'b0;
        rv_seen = 0;
        @(negedge clk);
        check("abort ready after", W'(req_ready), W'(1));
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) rv_seen++;
            @(negedge clk);
        end
        check("abort no resp", W'(rv_seen), '0);

        for (int i = 0; i < 60; i++) begin
            v.is_store = 1'($urandom_range(0, 1));
            v.size     = 2'($urandom_range(0, 3));
            v.sign     = 1'($urandom_range(0, 1));
            v.addr     = $urandom;
            v.wdata    = $urandom;
            v.rdata    = $urandom;
            v.delay    = $urandom_range(1, TO + 3);
            apply(model(v), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
